instr_loader: RTL and testbench

Sequential instruction encoder and instruction-memory loader for the single-cycle CPU. It accepts field-level instruction requests (R-type or I-type ALU operations) over a valid/ready handshake and assembles each into a 32-bit RV32I word using the same opcodes the control decoder recognises (0110011 / 0010011). It writes each word into instruction memory at consecutive word addresses, using a write/acknowledge handshake. It sits between the testbench/boot stimulus and the instruction memory, ahead of the fetch path.

---
 rtl/instr_loader.sv | 116 +++++++++++
 tb/tb_instr_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Field-level RV32I ALU instruction encoder that streams encoded words into
// instruction memory at consecutive word addresses over a write/ack handshake.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_kind_i,
  input  logic        req_last_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  output logic [15:0] count_o,
  output logic        done_o
);

  localparam logic [6:0]  OpcReg = 7'b0110011;
  localparam logic [6:0]  OpcImm = 7'b0010011;
  localparam logic [15:0] DepthW = 16'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] enc_word;
  logic [15:0] count_base;
  logic [15:0] count_inc;

  always_comb begin
    if (req_kind_i) begin
      enc_word = {imm_i, rs1_i, funct3_i, rd_i, OpcImm};
    end else begin
      enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OpcReg};
    end
  end

  // A clear arriving together with a request restarts the program at BASE_ADDR.
  assign count_base = clear_i ? 16'd0 : count_q;
  assign count_inc  = count_q + 16'd1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          count_d = 16'd0;
          last_d  = 1'b0;
          addr_d  = BASE_ADDR;
        end
        if (req_valid_i) begin
          data_d  = enc_word;
          addr_d  = BASE_ADDR + {14'd0, count_base, 2'b00};
          last_d  = req_last_i;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (mem_ack_i) begin
          count_d = count_inc;
          state_d = (last_q || count_inc == DepthW) ? StDone : StIdle;
        end
      end
      StDone: begin
        if (clear_i) begin
          count_d = 16'd0;
          last_d  = 1'b0;
          addr_d  = BASE_ADDR;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      count_q <= 16'd0;
      last_q  <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign mem_we_o    = (state_q == StWrite);
  assign done_o      = (state_q == StDone);
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of encoded instructions plus
// hand-written handshake sequences, with a write scoreboard.
module tb_instr_loader;

  localparam logic [31:0] Base  = 32'h0000_0000;
  localparam int          Depth = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_kind_i = 1'b0;
  logic        req_last_i = 1'b0;
  logic [6:0]  funct7_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [11:0] imm_i = '0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] count_o;
  logic        done_o;

  instr_loader #(.BASE_ADDR(Base), .DEPTH(Depth)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_kind_i(req_kind_i), .req_last_i(req_last_i),
    .funct7_i(funct7_i), .funct3_i(funct3_i), .rd_i(rd_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .imm_i(imm_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .count_o(count_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        last;
    logic [31:0] data;
  } vec_t;

  vec_t        tbl[6];
  logic [63:0] sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          exp_count = 0;
  bit          exp_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every acknowledged write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_i && mem_we_o && mem_ack_i) begin
      n_writes++;
      if (sb.size() == 0) begin
        chk("unexpected_write", mem_addr_o, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wr_addr", mem_addr_o, e[63:32]);
        chk("wr_data", mem_data_o, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input bit lst);
    req_kind_i = v.kind;
    funct7_i   = v.f7;
    funct3_i   = v.f3;
    rd_i       = v.rd;
    rs1_i      = v.rs1;
    rs2_i      = v.rs2;
    imm_i      = v.imm;
    req_last_i = lst;
    req_valid_i = 1'b1;
  endtask

  task automatic scramble();
    req_valid_i = 1'b0;
    req_kind_i  = 1'($urandom);
    req_last_i  = 1'($urandom);
    funct7_i    = 7'($urandom);
    funct3_i    = 3'($urandom);
    rd_i        = 5'($urandom);
    rs1_i       = 5'($urandom);
    rs2_i       = 5'($urandom);
    imm_i       = 12'($urandom);
  endtask

  task automatic send(input int idx, input int wait_cyc, input int clear_cyc, input bit no_last);
    vec_t        v;
    bit          lst;
    logic [31:0] ea;
    v   = tbl[idx];
    lst = v.last && !no_last;
    ea  = Base + 32'(exp_count) * 32'd4;
    if (exp_done) begin
      drive(v, lst);
      mem_ack_i = 1'b1;
      tick();
      scramble();
      mem_ack_i = 1'b0;
      chk("done_ign_we", {31'd0, mem_we_o}, 32'd0);
      chk("done_ign_ready", {31'd0, req_ready_o}, 32'd0);
      chk("done_ign_count", {16'd0, count_o}, 32'(exp_count));
    end else begin
      chk("idle_ready", {31'd0, req_ready_o}, 32'd1);
      drive(v, lst);
      mem_ack_i = 1'b1;  // ack outside WRITE must be ignored
      sb.push_back({ea, v.data});
      tick();
      scramble();
      for (int i = 0; i < wait_cyc; i++) begin
        mem_ack_i = 1'b0;
        clear_i = (i == clear_cyc);
        chk("stall_we", {31'd0, mem_we_o}, 32'd1);
        chk("stall_ready", {31'd0, req_ready_o}, 32'd0);
        chk("stall_addr", mem_addr_o, ea);
        chk("stall_data", mem_data_o, v.data);
        chk("stall_count", {16'd0, count_o}, 32'(exp_count));
        tick();
      end
      clear_i   = 1'b0;
      mem_ack_i = 1'b1;
      chk("wr_we", {31'd0, mem_we_o}, 32'd1);
      chk("wr_ready", {31'd0, req_ready_o}, 32'd0);
      tick();
      mem_ack_i = 1'b0;
      exp_count++;
      if (lst || exp_count == Depth) exp_done = 1'b1;
      chk("post_count", {16'd0, count_o}, 32'(exp_count));
      chk("post_done", {31'd0, done_o}, {31'd0, exp_done});
      chk("post_ready", {31'd0, req_ready_o}, {31'd0, !exp_done});
      chk("post_we", {31'd0, mem_we_o}, 32'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    chk({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_addr"}, mem_addr_o, Base);
    chk({tag, "_data"}, mem_data_o, 32'd0);
    chk({tag, "_count"}, {16'd0, count_o}, 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    exp_count = 0;
    exp_done = 1'b0;
    sb.delete();
    tick();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    exp_count = 0;
    exp_done = 1'b0;
    chk("clr_count", {16'd0, count_o}, 32'd0);
    chk("clr_ready", {31'd0, req_ready_o}, 32'd1);
    chk("clr_done", {31'd0, done_o}, 32'd0);
    chk("clr_addr", mem_addr_o, Base);
  endtask

  initial begin
    int w0;
    tbl[0] = '{1'b0, 7'h00, 3'd0, 5'd3,  5'd1,  5'd2,  12'hABC, 1'b0, 32'h002081B3}; // add
    tbl[1] = '{1'b1, 7'h7F, 3'd0, 5'd5,  5'd0,  5'd31, 12'hFFF, 1'b0, 32'hFFF00293}; // addi -1
    tbl[2] = '{1'b0, 7'h20, 3'd0, 5'd4,  5'd3,  5'd2,  12'h000, 1'b1, 32'h40218233}; // sub
    tbl[3] = '{1'b1, 7'h55, 3'd4, 5'd7,  5'd6,  5'd9,  12'h123, 1'b0, 32'h12334393}; // xori
    tbl[4] = '{1'b0, 7'h00, 3'd7, 5'd10, 5'd11, 5'd12, 12'h800, 1'b0, 32'h00C5F533}; // and
    tbl[5] = '{1'b1, 7'h00, 3'd2, 5'd1,  5'd2,  5'd0,  12'h800, 1'b0, 32'h80012093}; // slti

    tick();
    check_reset_vals("rst");
    rst_i = 1'b1;
    tick();
    check_reset_vals("rel");

    send(0, 0, -1, 1'b0);                 // zero-wait add
    do_reset();
    send(1, 0, -1, 1'b0);                 // addi @0x0
    send(2, 0, -1, 1'b0);                 // sub @0x4, last
    chk("last_done", {31'd0, done_o}, 32'd1);
    w0 = n_writes;
    send(3, 0, -1, 1'b0);
    send(4, 0, -1, 1'b0);
    chk("done_no_write", 32'(n_writes - w0), 32'd0);

    do_clear();
    send(3, 3, -1, 1'b0);                 // 3-cycle ack stall @BASE
    send(4, 2, 0, 1'b0);                  // clear during WRITE ignored
    chk("clr_in_write_count", {16'd0, count_o}, 32'd2);

    do_clear();
    w0 = n_writes;
    for (int k = 0; k < 6; k++) send(k, k % 2, -1, 1'b1);
    chk("depth_writes", 32'(n_writes - w0), 32'd4);
    chk("depth_count", {16'd0, count_o}, 32'd4);
    chk("depth_done", {31'd0, done_o}, 32'd1);

    do_clear();
    drive(tbl[5], 1'b0);
    mem_ack_i = 1'b0;
    tick();
    scramble();
    chk("rstw_we", {31'd0, mem_we_o}, 32'd1);
    tick();
    rst_i = 1'b0;
    #1;
    check_reset_vals("rstw");
    tick();
    rst_i = 1'b1;
    tick();
    check_reset_vals("rstw_rel");
    send(0, 1, -1, 1'b0);                 // must land at BASE_ADDR

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
